instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have a parameter SIZE, default 32, giving the instruction word width in bits.
REQ-002 The block SHALL have a parameter MAX_INSTRUCTION, default 64, giving the instruction memory depth in words.
REQ-003 The block SHALL derive a local parameter ADDR_WIDTH = $clog2(MAX_INSTRUCTION); it is not overridable.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_start, input, 1 bit: starts a program load.
REQ-007 The block SHALL have port i_rx_data, input, 8 bits: incoming program byte.
REQ-008 The block SHALL have port i_rx_valid, input, 1 bit: i_rx_data is valid.
REQ-009 The block SHALL have port o_rx_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-010 The block SHALL have port o_inst_write_enable, output, 1 bit: instruction memory write strobe.
REQ-011 The block SHALL have port o_write_addr, output, ADDR_WIDTH bits: instruction memory word address.
REQ-012 The block SHALL have port o_write_data, output, SIZE bits: instruction word to write.
REQ-013 The block SHALL have port o_busy, output, 1 bit: a load is in progress.
REQ-014 The block SHALL have port o_done, output, 1 bit: the load completed with a halt word.
REQ-015 The block SHALL have port o_overflow_error, output, 1 bit: memory filled without a halt word.
REQ-016 The block SHALL have port o_word_count, output, ADDR_WIDTH+1 bits: number of words written in the current or last load.

Function
REQ-017 The state machine SHALL have the states IDLE, RECV, WRITE, DONE and ERROR; all outputs are registered.
REQ-018 In IDLE, DONE or ERROR, i_start=1 SHALL cause a move to RECV next cycle, clearing the byte counter, the address, o_word_count, o_done and o_overflow_error.
REQ-019 In RECV and WRITE, i_start SHALL be ignored.
REQ-020 o_rx_ready SHALL be 1 only in RECV; a byte is accepted on any rising edge with i_rx_valid=1 and o_rx_ready=1.
REQ-021 i_rx_valid SHALL be ignored outside RECV; data is neither accepted nor buffered.
REQ-022 Bytes SHALL assemble big-endian: 1st accepted byte -> bits [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
REQ-023 Acceptance of the 4th byte SHALL move the block to WRITE; o_rx_ready is 0 in the following cycle.
REQ-024 In WRITE, o_inst_write_enable SHALL be 1 for exactly one cycle, with o_write_addr and o_write_data stable for that cycle.
REQ-025 o_write_data and o_write_addr SHALL hold their last values when o_inst_write_enable=0.
REQ-026 On leaving WRITE, o_word_count SHALL increment by 1 and o_write_addr SHALL increment by 1.
REQ-027 If the word written is 32'hFFFF_FFFF (halt), the block SHALL move WRITE -> DONE.
REQ-028 Otherwise, if o_word_count reaches MAX_INSTRUCTION, the block SHALL move WRITE -> ERROR, and o_write_addr SHALL wrap to 0.
REQ-029 Otherwise, the block SHALL move WRITE -> RECV.
REQ-030 A halt word written at address MAX_INSTRUCTION-1 SHALL give DONE, not ERROR.
REQ-031 o_busy SHALL be 1 in RECV and WRITE, and 0 otherwise.
REQ-032 In DONE, o_done SHALL be 1; in ERROR, o_overflow_error SHALL be 1; each is held until the next i_start.
REQ-033 Minimum word period SHALL be 5 cycles: 4 accept cycles plus 1 write cycle.

Reset
REQ-034 Assertion of i_rst_n=0 SHALL immediately force IDLE and drive all outputs to 0: o_rx_ready, o_inst_write_enable, o_write_addr, o_write_data, o_busy, o_done, o_overflow_error, o_word_count.
REQ-035 Reset asserted mid-load, including during WRITE, SHALL abort the load, with no further write strobe and the partial word discarded.
REQ-036 After i_rst_n rises, the block SHALL remain in IDLE until i_start.

Verification
REQ-037 Basic load: start; bytes 20 01 00 05, FF FF FF FF with valid held high -> writes addr0=0x20010005 at cycle 5 after start acceptance, then addr1=0xFFFFFFFF; o_done=1; o_word_count=2.
REQ-038 Backpressure gaps: valid toggled 1/0 per byte -> same words and addresses; no byte lost or duplicated; write strobe exactly 1 cycle each.
REQ-039 Overflow: 64 non-halt words (e.g. 0x00000001) -> 64 strobes at addr 0..63; then ERROR, o_overflow_error=1, o_word_count=64, o_rx_ready=0.
REQ-040 Halt at last slot: 63 non-halt words then 0xFFFFFFFF -> strobe at addr 63, o_done=1, o_overflow_error=0, o_word_count=64.
REQ-041 Reset mid-word: 2 bytes accepted, then i_rst_n=0 -> all outputs 0 asynchronously; after release plus start, a fresh 4 bytes write to addr 0 with no stale bytes.
REQ-042 Ignored start: i_start pulsed during RECV -> no counter or address change; a start from DONE clears o_done and restarts at addr 0.

Source files
------------

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Receives a program as a stream of bytes and packs them
//               big-endian into instruction words. Each word is written to
//               instruction memory with a one-cycle strobe. Loading stops
//               after an all-ones halt word (done) or when memory is full
//               (overflow error).
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 64,
  localparam int ADDR_WIDTH     = $clog2(MAX_INSTRUCTION)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow_error,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = SIZE / 8;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD) + 1;

  localparam logic [BYTE_CNT_W-1:0] c_last_byte = BYTE_CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH:0]   c_max_count = (ADDR_WIDTH + 1)'(MAX_INSTRUCTION);
  localparam logic [SIZE-1:0]       c_halt_word = '1;

  state_t                r_state;
  state_t                w_next_state;
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [SIZE-1:0]       r_word;
  logic [SIZE-1:0]       w_next_word;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_last_byte;
  logic                  w_is_halt;
  logic                  w_count_full;

  // o_rx_ready is high exactly while in RECV, so it doubles as the accept qualifier
  assign w_accept     = o_rx_ready & i_rx_valid;
  assign w_start      = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
  assign w_next_word  = (r_word << 8) | SIZE'(i_rx_data);
  assign w_last_byte  = (r_byte_cnt == c_last_byte);
  assign w_is_halt    = (o_write_data == c_halt_word);
  assign w_count_full = ((o_word_count + (ADDR_WIDTH + 1)'(1)) == c_max_count);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; halt takes priority over a full memory
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) w_next_state = S_RECV;
      end
      S_RECV: begin
        if (w_accept && w_last_byte) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (w_is_halt)         w_next_state = S_DONE;
        else if (w_count_full) w_next_state = S_ERROR;
        else                   w_next_state = S_RECV;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs and datapath: byte packing, address and word counting
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_ready          <= 1'b0;
      o_inst_write_enable <= 1'b0;
      o_write_addr        <= '0;
      o_write_data        <= '0;
      o_busy              <= 1'b0;
      o_done              <= 1'b0;
      o_overflow_error    <= 1'b0;
      o_word_count        <= '0;
      r_byte_cnt          <= '0;
      r_word              <= '0;
    end else begin
      o_rx_ready          <= (w_next_state == S_RECV);
      o_busy              <= (w_next_state == S_RECV) || (w_next_state == S_WRITE);
      o_inst_write_enable <= (w_next_state == S_WRITE);
      o_done              <= (w_next_state == S_DONE);
      o_overflow_error    <= (w_next_state == S_ERROR);
      if (w_start) begin
        r_byte_cnt   <= '0;
        r_word       <= '0;
        o_write_addr <= '0;
        o_word_count <= '0;
      end else begin
        if (w_accept) begin
          r_word     <= w_next_word;
          r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BYTE_CNT_W'(1);
          if (w_last_byte) o_write_data <= w_next_word;
        end
        if (r_state == S_WRITE) begin
          o_word_count <= o_word_count + (ADDR_WIDTH + 1)'(1);
          o_write_addr <= (w_next_state == S_ERROR) ? '0 : o_write_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Self-checking bench for instruction_loader: reset state,
//               table-driven program loads, randomized loads checked against
//               a reference model, and hand-written timing/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

  localparam int SIZE = 32;
  localparam int MAXI = 64;
  localparam int AW   = $clog2(MAXI);

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic          o_inst_write_enable;
  logic [AW-1:0] o_write_addr;
  logic [31:0]   o_write_data;
  logic          o_busy;
  logic          o_done;
  logic          o_overflow_error;
  logic [AW:0]   o_word_count;

  instruction_loader #(.SIZE(SIZE), .MAX_INSTRUCTION(MAXI)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (i_start),
    .i_rx_data           (i_rx_data),
    .i_rx_valid          (i_rx_valid),
    .o_rx_ready          (o_rx_ready),
    .o_inst_write_enable (o_inst_write_enable),
    .o_write_addr        (o_write_addr),
    .o_write_data        (o_write_data),
    .o_busy              (o_busy),
    .o_done              (o_done),
    .o_overflow_error    (o_overflow_error),
    .o_word_count        (o_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];      // strobes observed on the memory port
  wr_t         exp_q[$];   // strobes the reference model predicts
  logic [31:0] words_q[$]; // program stimulus
  bit          m_done;
  bit          m_err;
  logic        prev_we = 1'b0;

  // Record every write strobe; a strobe never lasts two cycles
  always @(negedge clk) begin
    if (o_inst_write_enable) begin
      wq.push_back('{int'(o_write_addr), o_write_data});
      check("strobe_single_cycle", prev_we, 1'b0);
      check("busy_during_strobe", o_busy, 1'b1);
    end
    prev_we = o_inst_write_enable;
  end

  // Reference model: words go to consecutive addresses until a halt word
  // is stored or the memory holds MAXI words.
  task automatic model_build();
    exp_q.delete();
    m_done = 0;
    m_err  = 0;
    foreach (words_q[i]) begin
      exp_q.push_back('{i, words_q[i]});
      if (words_q[i] == 32'hFFFF_FFFF) begin
        m_done = 1;
        break;
      end
      if (exp_q.size() == MAXI) begin
        m_err = 1;
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom);
    end
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    t = 0;
    while (!o_rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("rx_ready_timeout", 1'b0, 1'b1);
      return;
    end
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int gap_mode, input bit e_done,
                          input bit e_err, input int e_count);
    logic [31:0] w;
    int          gap;
    int          bad;
    model_build();
    wq.delete();
    pulse_start();
    check({tag, "_start_done"}, o_done, 1'b0);
    check({tag, "_start_err"}, o_overflow_error, 1'b0);
    check({tag, "_start_count"}, o_word_count, 0);
    check({tag, "_start_ready"}, o_rx_ready, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      w = exp_q[i].data;
      for (int b = 0; b < 4; b++) begin
        gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
        send_byte(w[31-8*b -: 8], gap);
      end
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, wq.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      if (wq[i].addr != exp_q[i].addr || wq[i].data !== exp_q[i].data) bad++;
    check({tag, "_write_seq_errors"}, bad, 0);
    check({tag, "_done"}, o_done, e_done);
    check({tag, "_overflow"}, o_overflow_error, e_err);
    check({tag, "_word_count"}, o_word_count, e_count);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_rx_ready"}, o_rx_ready, 1'b0);
    check({tag, "_addr_after"}, o_write_addr, e_count % MAXI);
    check({tag, "_data_held"}, o_write_data, exp_q[exp_q.size()-1].data);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, o_rx_ready, 0);
    check({tag, "_we"}, o_inst_write_enable, 0);
    check({tag, "_addr"}, o_write_addr, 0);
    check({tag, "_data"}, o_write_data, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_overflow"}, o_overflow_error, 0);
    check({tag, "_count"}, o_word_count, 0);
  endtask

  typedef struct {
    int    nwords;
    int    halt_pos;
    int    gap_mode;
    bit    exp_done;
    bit    exp_err;
    int    exp_count;
    string name;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2,  1,  1, 1'b1, 1'b0, 2,  "gaps_toggle"};
    vecs[1] = '{64, -1, 0, 1'b0, 1'b1, 64, "overflow"};
    vecs[2] = '{64, 63, 1, 1'b1, 1'b0, 64, "halt_last_slot"};
    vecs[3] = '{1,  0,  2, 1'b1, 1'b0, 1,  "halt_first"};
    vecs[4] = '{10, 4,  2, 1'b1, 1'b0, 5,  "halt_mid"};
    vecs[5] = '{70, -1, 2, 1'b0, 1'b1, 64, "overflow_extra"};

    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset_busy", o_busy, 1'b0);
    check("idle_after_reset_ready", o_rx_ready, 1'b0);

    // Basic load with exact strobe timing, valid held high throughout
    wq.delete();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0; i_rx_valid = 1'b1; i_rx_data = 8'h20;
    @(negedge clk); i_rx_data = 8'h01;
    @(negedge clk); i_rx_data = 8'h00;
    @(negedge clk); i_rx_data = 8'h05;
    check("basic_no_early_strobe", o_inst_write_enable, 1'b0);
    @(negedge clk); i_rx_data = 8'hFF;
    check("basic_strobe", o_inst_write_enable, 1'b1);
    check("basic_addr0", o_write_addr, 0);
    check("basic_data0", o_write_data, 32'h2001_0005);
    check("basic_ready_in_write", o_rx_ready, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(8'hFF, 0);
    @(negedge clk); i_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("basic_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      check("basic_addr1", wq[1].addr, 1);
      check("basic_data1", wq[1].data, 32'hFFFF_FFFF);
    end
    check("basic_done", o_done, 1'b1);
    check("basic_count", o_word_count, 2);

    // Table-driven loads
    foreach (vecs[v]) begin
      words_q.delete();
      for (int i = 0; i < vecs[v].nwords; i++)
        words_q.push_back(i == vecs[v].halt_pos ? 32'hFFFF_FFFF : 32'(i + 1));
      run_load(vecs[v].name, vecs[v].gap_mode, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_count);
    end

    // Start pulsed mid-load must be ignored
    wq.delete();
    pulse_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk); i_rx_valid = 1'b0; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    @(negedge clk); i_rx_valid = 1'b0; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int b = 0; b < 4; b++) send_byte(8'hFF, 1);
    @(negedge clk); i_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ignstart_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      check("ignstart_data0", wq[0].data, 32'h1234_5678);
      check("ignstart_addr1", wq[1].addr, 1);
    end
    check("ignstart_count", o_word_count, 2);

    // Reset after two bytes of a word
    pulse_start();
    send_byte(8'h99, 0);
    send_byte(8'h88, 0);
    @(negedge clk); i_rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_midword");
    @(negedge clk); rst_n = 1'b1;

    // Reset while the write strobe is high
    wq.delete();
    pulse_start();
    for (int b = 0; b < 4; b++) send_byte(8'h11 * 8'(b + 1), 0);
    #1 check("rst_write_strobe_seen", o_inst_write_enable, 1'b1);
    rst_n = 1'b0;
    #1 check_all_zero("rst_in_write");
    @(negedge clk); rst_n = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'hEE;
    repeat (3) @(negedge clk);
    check("rst_write_no_strobe", wq.size(), 0);
    check("rst_stays_idle", o_busy, 1'b0);
    i_rx_valid = 1'b0;
    words_q = '{32'hAABB_CCDD, 32'hFFFF_FFFF};
    run_load("after_reset", 0, 1'b1, 1'b0, 2);

    // Randomized loads checked against the model
    for (int r = 0; r < 6; r++) begin
      int len;
      int hpos;
      logic [31:0] w;
      len  = int'($urandom_range(1, 80));
      hpos = int'($urandom_range(0, 90));
      words_q.delete();
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        words_q.push_back(i == hpos ? 32'hFFFF_FFFF : w);
      end
      if (hpos >= len && len < MAXI) words_q[len-1] = 32'hFFFF_FFFF;
      model_build();
      run_load($sformatf("rand%0d", r), 2, m_done, m_err, exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
